// File: rtl/seg7_pkg.sv
// Shared segment encodings for the seven-segment scan driver.
// Segment vectors are active-low, bit 0 = a .. bit 6 = g.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_ALL   = 7'h00;

  localparam seg_t HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex nibble to active-low segment pattern decode.
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver with tear-free updates,
// leading-zero suppression, per-digit decimal points and PWM dimming.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank,
  input  logic                    test,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
  logic [VAL_W-1:0]      active_q, active_d;
  logic [VAL_W-1:0]      pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  frame_done_q, frame_done_d;

  logic                  presc_last, frame_wrap;
  logic                  lz_run;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [NUM_DIGITS-1:0] digit_oh;
  logic [3:0]            nib_sel;
  logic                  dp_sel, supp_sel;
  logic                  scan_on, pwm_on;
  logic [6:0]            lut_seg_n;

  seg7_hex_lut u_hex_lut (
    .nibble (nib_sel),
    .seg_n  (lut_seg_n)
  );

  always_comb begin
    presc_last = (presc_q == PRE_LAST);
    frame_wrap = presc_last && (idx_q == IDX_LAST);
    presc_d    = presc_last ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    if (presc_last) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    pwm_d = pwm_q + 1'b1;
  end

  // Shown value only changes on the frame wrap so a scan never mixes two values.
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    active_d     = active_q;
    if (load) begin
      pend_d       = value;
      pend_valid_d = 1'b1;
    end
    if (frame_wrap) begin
      if (load) begin
        active_d     = value;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        active_d     = pend_q;
        pend_valid_d = 1'b0;
      end
    end
  end

  // lz_mask[k] is set when nibble k and every nibble above it are zero.
  always_comb begin
    lz_run  = 1'b1;
    lz_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run     = lz_run & (active_q[4*k +: 4] == 4'h0);
      lz_mask[k] = lz_run;
    end
  end

  always_comb begin
    nib_sel  = '0;
    dp_sel   = 1'b0;
    supp_sel = 1'b0;
    digit_oh = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_sel     = active_q[4*k +: 4];
        dp_sel      = dp_in[k];
        supp_sel    = lz_suppress & lz_mask[k];
        digit_oh[k] = 1'b1;
      end
    end
  end

  // Prescaler slot 0 keeps every anode dark while segments switch digits.
  always_comb begin
    scan_on      = (presc_q != '0);
    pwm_on       = (pwm_q <= brightness);
    seg_n_d      = SEG_BLANK;
    dp_n_d       = 1'b1;
    an_n_d       = '1;
    frame_done_d = frame_wrap;
    if (test) begin
      seg_n_d = SEG_ALL;
      dp_n_d  = 1'b0;
      if (scan_on) begin
        an_n_d = ~digit_oh;
      end
    end else if (!blank) begin
      seg_n_d = supp_sel ? SEG_BLANK : lut_seg_n;
      dp_n_d  = ~dp_sel;
      if (scan_on && pwm_on) begin
        an_n_d = ~digit_oh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      active_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      seg_n_q      <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule
